l0_seq_ctrl: RTL and testbench

//  Parametrised sequencer that replaces hand-driven L0 stimulus with autonomous control of one PE-array core.

---
 rtl/l0_seq_ctrl_if.sv | 22 ++
 rtl/l0_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_l0_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l0_seq_ctrl_if.sv
// L0 sequencer memory-side bundle: SRAM read port plus L0 FIFO
// write/read strobes and status, seen from sequencer (master).
interface l0_seq_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              mem_cen;
    logic [ADDR_W-1:0] mem_addr;
    logic              wr_l0;
    logic              rd_l0;
    logic              l0_full;
    logic              l0_valid;

    modport master (
        output mem_cen, mem_addr, wr_l0, rd_l0,
        input  l0_full, l0_valid
    );

    modport slave (
        input  mem_cen, mem_addr, wr_l0, rd_l0,
        output l0_full, l0_valid
    );
endinterface

// File: rtl/l0_seq_ctrl.sv
// L0 sequencer: fetches weight then activation vectors into L0 and
// steps one PE-array core through kernel load, execute and drain.
module l0_seq_ctrl #(
    parameter int row      = 4,
    parameter int col      = 4,
    parameter int L0_DEPTH = 64,
    parameter int ADDR_W   = 11,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [CNT_W-1:0]  n_w,
    input  logic [CNT_W-1:0]  n_a,
    l0_seq_ctrl_if.master     l0,
    output logic [1:0]        inst_w,
    output logic              mode,
    output logic              busy,
    output logic              done
);
    localparam int OCC_W = $clog2(L0_DEPTH + 1);
    localparam int TMR_W = $clog2(row + col + 1);
    localparam int SUM_W = OCC_W + 1;

    localparam logic [CNT_W-1:0]  C_ONE    = 1;
    localparam logic [OCC_W-1:0]  O_ONE    = 1;
    localparam logic [TMR_W-1:0]  T_ONE    = 1;
    localparam logic [ADDR_W-1:0] A_ONE    = 1;
    localparam logic [CNT_W-1:0]  ROW_C    = CNT_W'(row);
    localparam logic [TMR_W-1:0]  GAP_LAST = TMR_W'(row + col - 1);
    localparam logic [SUM_W-1:0]  DEPTH_C  = SUM_W'(L0_DEPTH);

    typedef enum logic [2:0] {
        IDLE, W_FETCH, W_LOAD, W_GAP, A_STREAM, FLUSH, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] a_base_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  n_w_q, n_a_q, n_tgt;
    logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SUM_W-1:0]  credit_use;
    logic              wr_q;
    logic              fetch_ph, read_ph, timed_ph;
    logic              issue, rd, rd_last, tmr_last, phase_chg;

    assign n_tgt    = (state_q inside {W_FETCH, W_LOAD}) ? n_w_q : n_a_q;
    assign fetch_ph = state_q inside {W_FETCH, A_STREAM};
    assign read_ph  = state_q inside {W_LOAD, A_STREAM};
    assign timed_ph = state_q inside {W_GAP, FLUSH};

    // In-flight read counts against the credit so L0 can never overflow.
    assign credit_use = {1'b0, occ_q} + {{OCC_W{1'b0}}, wr_q};
    assign issue      = fetch_ph && (iss_cnt_q != n_tgt) &&
                        (credit_use < DEPTH_C) && !l0.l0_full;
    assign rd         = read_ph && l0.l0_valid && (rd_cnt_q != n_tgt);
    assign rd_last    = rd && ((rd_cnt_q + C_ONE) == n_tgt);
    assign tmr_last   = tmr_q == GAP_LAST;
    assign phase_chg  = state_d != state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = W_FETCH;
            W_FETCH: begin
                // Last write lands on this edge: latency is one cycle.
                if (iss_cnt_q == n_w_q) begin
                    if (n_w_q != '0)      state_d = W_LOAD;
                    else if (n_a_q != '0) state_d = A_STREAM;
                    else                  state_d = DONE;
                end
            end
            W_LOAD:   if (rd_last) state_d = W_GAP;
            W_GAP:    if (tmr_last) state_d = (n_a_q != '0) ? A_STREAM : DONE;
            A_STREAM: if (rd_last) state_d = FLUSH;
            FLUSH:    if (tmr_last) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q == IDLE && start) begin
            addr_d = w_base;
        end else if (issue) begin
            addr_d = addr_q + A_ONE;
        end else if (state_q == W_FETCH && phase_chg) begin
            addr_d = a_base_q;
        end

        iss_cnt_d = phase_chg ? '0 : (issue ? iss_cnt_q + C_ONE : iss_cnt_q);
        rd_cnt_d  = phase_chg ? '0 : (rd ? rd_cnt_q + C_ONE : rd_cnt_q);
        tmr_d     = (phase_chg || !timed_ph) ? '0 : tmr_q + T_ONE;

        unique case ({wr_q, rd})
            2'b10:   occ_d = occ_q + O_ONE;
            2'b01:   occ_d = occ_q - O_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_base_q  <= '0;
            addr_q    <= '0;
            n_w_q     <= '0;
            n_a_q     <= '0;
            iss_cnt_q <= '0;
            rd_cnt_q  <= '0;
            tmr_q     <= '0;
            occ_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                a_base_q <= a_base;
                n_w_q    <= (n_w > ROW_C) ? ROW_C : n_w;
                n_a_q    <= n_a;
            end
            addr_q    <= addr_d;
            iss_cnt_q <= iss_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            tmr_q     <= tmr_d;
            occ_q     <= occ_d;
            wr_q      <= issue;
        end
    end

    always_comb begin
        l0.mem_cen  = !issue;
        l0.mem_addr = addr_q;
        l0.wr_l0    = wr_q;
        l0.rd_l0    = rd;
        inst_w      = 2'b00;
        if (rd) begin
            inst_w = (state_q == A_STREAM) ? 2'b10 : 2'b01;
        end
        mode = state_q inside {A_STREAM, FLUSH, DONE};
        busy = state_q != IDLE;
        done = state_q == DONE;
    end
endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Scoreboard bench for l0_seq_ctrl: SRAM returns its address as data,
// a queue models L0, and a negedge monitor pops expected traffic.
module tb_l0_seq_ctrl;
    localparam int ROW   = 4;
    localparam int COL   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 11;
    localparam int CW    = 8;

    typedef struct packed {
        logic [1:0]    inst;
        logic          mode;
        logic [AW-1:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] a_base = '0;
    logic [CW-1:0] n_w = '0;
    logic [CW-1:0] n_a = '0;
    logic [1:0]    inst_w;
    logic          mode, busy, done;

    l0_seq_ctrl_if #(.ADDR_W(AW)) l0 ();

    l0_seq_ctrl #(
        .row(ROW), .col(COL), .L0_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .n_w(n_w), .n_a(n_a),
        .l0(l0.master),
        .inst_w(inst_w), .mode(mode), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] exp_addr[$];
    rd_exp_t       exp_rd[$];
    int            exp_done[$];
    logic [AW-1:0] fifo[$];

    logic          hold = 1'b0;
    logic          force_full = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          prev_issue = 1'b0;
    logic          prev_done = 1'b0;
    int            n_wr = 0, n_rd = 0, hold_max = 0;
    int            wr0 = 0, rd0 = 0;
    rd_exp_t       mon_e;
    logic [AW-1:0] mon_d;
    int            mon_c;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event at t=%0t", nm, $time);
    endtask

    // L0 status is driven just after each edge from the model contents.
    initial begin
        l0.l0_valid = 1'b0;
        l0.l0_full  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            l0.l0_valid = (fifo.size() > 0) && !hold;
            l0.l0_full  = (fifo.size() >= DEPTH) || force_full;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            fifo.delete();
            prev_issue = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (l0.wr_l0 || prev_issue)
                check("wr_l0_latency", l0.wr_l0, prev_issue);
            if (l0.l0_full)
                check("full_stall_cen", l0.mem_cen, 1);
            if (l0.rd_l0) begin
                n_rd++;
                if (exp_rd.size() == 0 || fifo.size() == 0) begin
                    fail_evt("rd_extra");
                end else begin
                    mon_e = exp_rd.pop_front();
                    mon_d = fifo.pop_front();
                    check("rd_inst_w", inst_w, mon_e.inst);
                    check("rd_mode", mode, mon_e.mode);
                    check("rd_data", mon_d, mon_e.data);
                end
            end
            if (l0.wr_l0) begin
                n_wr++;
                fifo.push_back(last_addr);
                n_cmp++;
                if (fifo.size() > DEPTH) begin
                    n_err++;
                    $display("FAIL occ_bound: got %0d expected <= %0d", fifo.size(), DEPTH);
                end
            end
            if (hold && fifo.size() > hold_max) hold_max = fifo.size();
            if (!l0.mem_cen) begin
                if (exp_addr.size() == 0) fail_evt("addr_extra");
                else check("mem_addr", l0.mem_addr, exp_addr.pop_front());
                last_addr = l0.mem_addr;
            end
            prev_issue = !l0.mem_cen;
            if (done) begin
                check("busy_at_done", busy, 1);
                if (exp_done.size() == 0) begin
                    fail_evt("done_extra");
                end else begin
                    mon_c = exp_done.pop_front();
                    if (mon_c >= 0) check("done_cycle", cyc, mon_c);
                end
            end
            if (prev_done) begin
                check("busy_after_done", busy, 0);
                check("mode_after_done", mode, 0);
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input int nw, input int na, input int rel);
        int nwe;
        nwe = (nw > ROW) ? ROW : nw;
        for (int i = 0; i < nwe; i++) begin
            exp_addr.push_back(AW'(wb + i));
            exp_rd.push_back(rd_exp_t'{inst: 2'b01, mode: 1'b0, data: AW'(wb + i)});
        end
        for (int i = 0; i < na; i++) begin
            exp_addr.push_back(AW'(ab + i));
            exp_rd.push_back(rd_exp_t'{inst: 2'b10, mode: 1'b1, data: AW'(ab + i)});
        end
        exp_done.push_back((rel < 0) ? -1 : cyc + rel);
        wr0    = n_wr;
        rd0    = n_rd;
        w_base = wb;
        a_base = ab;
        n_w    = CW'(nw);
        n_a    = CW'(na);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        w_base = ~wb;
        a_base = ~ab;
        n_w    = '1;
        n_a    = '1;
    endtask

    task automatic end_job(input string nm, input int ewr, input int erd);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_evt({nm, "_timeout"});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({nm, "_addr_left"}, exp_addr.size(), 0);
        check({nm, "_rd_left"}, exp_rd.size(), 0);
        check({nm, "_done_left"}, exp_done.size(), 0);
        check({nm, "_wr_total"}, n_wr - wr0, ewr);
        check({nm, "_rd_total"}, n_rd - rd0, erd);
    endtask

    task automatic check_reset_outs(input string nm);
        @(negedge clk);
        check({nm, "_cen"}, l0.mem_cen, 1);
        check({nm, "_addr"}, l0.mem_addr, 0);
        check({nm, "_wr"}, l0.wr_l0, 0);
        check({nm, "_rd"}, l0.rd_l0, 0);
        check({nm, "_inst"}, inst_w, 0);
        check({nm, "_mode"}, mode, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check_reset_outs("rst");

        // T2: weights 0..3, activations 16..23
        launch(11'd0, 11'd16, 4, 8, -1);
        end_job("t2", 12, 12);

        // T4: n_w clamped to row, with L0 full forced during fetch
        launch(11'd5, 11'd32, 9, 2, -1);
        force_full = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        force_full = 1'b0;
        end_job("t4", 6, 6);

        // T5: empty job completes two cycles after start
        launch(11'd16, 11'd32, 0, 0, 2);
        end_job("t5", 0, 0);

        // T6: address wrap 2046, 2047, 0, 1; mid-job start ignored
        launch(11'd0, 11'd2046, 0, 4, -1);
        @(posedge clk);
        #1;
        w_base = 11'd100;
        a_base = 11'd500;
        n_w    = 8'd3;
        n_a    = 8'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        end_job("t6", 4, 4);

        // T3: reads withheld; credit limit caps occupancy at DEPTH
        hold = 1'b1;
        launch(11'd0, 11'd256, 0, 16, -1);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        end_job("t3", 16, 16);
        check("t3_hold_max_occ", hold_max, DEPTH);

        // T1: reset during A_STREAM, then a clean job
        launch(11'd64, 11'd128, 2, 8, -1);
        k = 0;
        @(negedge clk);
        while (!mode && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!mode) fail_evt("t1_mode_timeout");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_addr.delete();
        exp_rd.delete();
        exp_done.delete();
        check_reset_outs("t1_abort");
        launch(11'd3, 11'd1000, 3, 5, -1);
        end_job("t1_rerun", 8, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
